// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage controller.
package fetch_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/grant/response bus between fetch and imem.
interface fetch_ctrl_if #(
  parameter int unsigned N = 64
);
  import fetch_pkg::*;

  logic               imem_req;
  logic [N-1:0]       imem_addr_F;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr_F,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr_F,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/adder.sv
// Generic N-bit adder shared by the datapath; carry-out is discarded.
module adder #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/fetch_skid.sv
// One-entry {instr, pc} buffer that catches a response while IF/ID is stalled.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               unload,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [N-1:0]       pc_in,
  output logic               full,
  output logic [INSTR_W-1:0] instr_out,
  output logic [N-1:0]       pc_out
);
  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [N-1:0]       pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full      = full_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, runs one imem read at a time and
// fills IF/ID, honouring decode stalls and branch redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_F,
  input  logic [N-1:0]       PCBranch_F,
  input  logic               stall_D,
  fetch_ctrl_if.master       imem,
  output logic               instr_valid_D,
  output logic [INSTR_W-1:0] instr_D,
  output logic [N-1:0]       pc_D
);
  localparam logic [N-1:0] INC = N'(PC_INC);

  fetch_state_e       state_q, state_d;
  logic [N-1:0]       pc_q, pc_d;
  logic [N-1:0]       req_pc_q, req_pc_d;
  logic               squash_q, squash_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [N-1:0]       pcd_q, pcd_d;

  logic               slot_free;
  logic [N-1:0]       pc_inc;
  logic               skid_load, skid_unload, skid_flush, skid_full;
  logic [INSTR_W-1:0] skid_instr;
  logic [N-1:0]       skid_pc;

  adder #(.N(N)) u_pc_inc (
    .a (req_pc_q),
    .b (INC),
    .y (pc_inc)
  );

  fetch_skid #(.N(N)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .unload    (skid_unload),
    .flush     (skid_flush),
    .instr_in  (imem.imem_rdata),
    .pc_in     (req_pc_q),
    .full      (skid_full),
    .instr_out (skid_instr),
    .pc_out    (skid_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    squash_d    = squash_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pcd_d       = pcd_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;
    slot_free   = !valid_q || !stall_D;

    if (!stall_D) valid_d = 1'b0;

    unique case (state_q)
      S_REQ: if (imem.imem_gnt) begin
        state_d  = S_WAIT;
        req_pc_d = pc_q;
      end
      S_WAIT: if (imem.imem_rvalid) begin
        state_d = S_REQ;
        if (squash_q) begin
          squash_d = 1'b0;
        end else begin
          pc_d = pc_inc;
          if (slot_free) begin
            valid_d = 1'b1;
            instr_d = imem.imem_rdata;
            pcd_d   = req_pc_q;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: if (slot_free && skid_full) begin
        valid_d     = 1'b1;
        instr_d     = skid_instr;
        pcd_d       = skid_pc;
        skid_unload = 1'b1;
        state_d     = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides everything above; an already granted or pending
    // request is marked for squash so its response is dropped on arrival.
    if (PCSrc_F) begin
      pc_d        = PCBranch_F;
      valid_d     = 1'b0;
      instr_d     = instr_q;
      pcd_d       = pcd_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_flush  = 1'b1;
      unique case (state_q)
        S_REQ: begin
          squash_d = imem.imem_gnt;
          state_d  = imem.imem_gnt ? S_WAIT : S_REQ;
        end
        S_WAIT: begin
          squash_d = !imem.imem_rvalid;
          state_d  = imem.imem_rvalid ? S_REQ : S_WAIT;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      squash_q <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
    end
  end

  assign imem.imem_req    = (state_q == S_REQ) && reset;
  assign imem.imem_addr_F = pc_q;
  assign instr_valid_D    = valid_q;
  assign instr_D          = instr_q;
  assign pc_D             = pcd_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: cycle vector table plus hand-written
// redirect, wrap-around and reset sequences.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrc_F;
  logic [63:0] PCBranch_F;
  logic        stall_D;
  logic        instr_valid_D;
  logic [31:0] instr_D;
  logic [63:0] pc_D;

  int checks = 0;
  int failures = 0;

  fetch_ctrl_if #(.N(64)) bus ();

  fetch_ctrl #(.N(64), .RESET_PC(64'd0)) dut (
    .clk           (clk),
    .reset         (reset),
    .PCSrc_F       (PCSrc_F),
    .PCBranch_F    (PCBranch_F),
    .stall_D       (stall_D),
    .imem          (bus),
    .instr_valid_D (instr_valid_D),
    .instr_D       (instr_D),
    .pc_D          (pc_D)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required run to finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [63:0] br;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic req, input logic [63:0] addr,
                         input logic valid, input logic [31:0] instr, input logic [63:0] pc);
    chk({tag, ".req"},   {63'd0, bus.imem_req}, {63'd0, req});
    chk({tag, ".addr"},  bus.imem_addr_F, addr);
    chk({tag, ".valid"}, {63'd0, instr_valid_D}, {63'd0, valid});
    chk({tag, ".instr"}, {32'd0, instr_D}, {32'd0, instr});
    chk({tag, ".pc"},    pc_D, pc);
  endtask

  task automatic drive(input logic s, input logic p, input logic [63:0] br,
                       input logic g, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    stall_D = s; PCSrc_F = p; PCBranch_F = br;
    bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = rd;
    #1;
  endtask

  initial begin
    // Sequential fetch at k=1, then a stall that fills the skid buffer.
    vt[0]  = '{1'b0,1'b0,64'd0,1'b1,1'b0,32'h0,        1'b1,64'd0, 1'b0,32'h0,        64'd0};
    vt[1]  = '{1'b0,1'b0,64'd0,1'b0,1'b1,32'h9100_0000, 1'b0,64'd0, 1'b0,32'h0,        64'd0};
    vt[2]  = '{1'b0,1'b0,64'd0,1'b1,1'b0,32'h0,        1'b1,64'd4, 1'b1,32'h9100_0000,64'd0};
    vt[3]  = '{1'b0,1'b0,64'd0,1'b0,1'b1,32'h9100_0004, 1'b0,64'd4, 1'b0,32'h9100_0000,64'd0};
    vt[4]  = '{1'b1,1'b0,64'd0,1'b1,1'b0,32'h0,        1'b1,64'd8, 1'b1,32'h9100_0004,64'd4};
    vt[5]  = '{1'b1,1'b0,64'd0,1'b0,1'b1,32'h9100_0008, 1'b0,64'd8, 1'b1,32'h9100_0004,64'd4};
    vt[6]  = '{1'b1,1'b0,64'd0,1'b0,1'b0,32'h0,        1'b0,64'd12,1'b1,32'h9100_0004,64'd4};
    vt[7]  = '{1'b0,1'b0,64'd0,1'b0,1'b0,32'h0,        1'b0,64'd12,1'b1,32'h9100_0004,64'd4};
    vt[8]  = '{1'b0,1'b0,64'd0,1'b1,1'b0,32'h0,        1'b1,64'd12,1'b1,32'h9100_0008,64'd8};
    vt[9]  = '{1'b0,1'b0,64'd0,1'b0,1'b1,32'h9100_000C, 1'b0,64'd12,1'b0,32'h9100_0008,64'd8};
    vt[10] = '{1'b0,1'b0,64'd0,1'b0,1'b0,32'h0,        1'b1,64'd16,1'b1,32'h9100_000C,64'd12};
    vt[11] = '{1'b0,1'b0,64'd0,1'b0,1'b0,32'h0,        1'b1,64'd16,1'b0,32'h9100_000C,64'd12};

    reset = 1'b0; PCSrc_F = 1'b0; PCBranch_F = '0; stall_D = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    exp_out("rst", 1'b0, 64'd0, 1'b0, 32'h0, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int unsigned i = 0; i < 12; i++) begin
      drive(vt[i].stall, vt[i].pcsrc, vt[i].br, vt[i].gnt, vt[i].rvalid, vt[i].rdata);
      exp_out($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
              vt[i].e_instr, vt[i].e_pc);
    end

    // Redirect to 8 without grant, then redirect to 0x100 while waiting (k=3).
    drive(0, 1, 64'h8,   0, 0, 0);           exp_out("d0", 1, 64'd16,  0, 32'h9100_000C, 64'd12);
    drive(0, 0, 0,       1, 0, 0);           exp_out("d1", 1, 64'h8,   0, 32'h9100_000C, 64'd12);
    drive(0, 1, 64'h100, 0, 0, 0);           exp_out("d2", 0, 64'h8,   0, 32'h9100_000C, 64'd12);
    drive(0, 0, 0,       0, 0, 0);           exp_out("d3", 0, 64'h100, 0, 32'h9100_000C, 64'd12);
    drive(0, 0, 0,       0, 1, 32'hDEAD_0008); exp_out("d4", 0, 64'h100, 0, 32'h9100_000C, 64'd12);
    drive(0, 0, 0,       1, 0, 0);           exp_out("d5", 1, 64'h100, 0, 32'h9100_000C, 64'd12);
    drive(0, 0, 0,       0, 1, 32'h9100_0100); exp_out("d6", 0, 64'h100, 0, 32'h9100_000C, 64'd12);
    drive(0, 1, 64'h20,  0, 0, 0);           exp_out("d7", 1, 64'h104, 1, 32'h9100_0100, 64'h100);

    // Redirect coinciding with grant of 0x20: that response must be dropped.
    drive(0, 1, 64'h400, 1, 0, 0);           exp_out("e0", 1, 64'h20,  0, 32'h9100_0100, 64'h100);
    drive(0, 0, 0,       0, 1, 32'hDEAD_0020); exp_out("e1", 0, 64'h400, 0, 32'h9100_0100, 64'h100);
    drive(0, 0, 0,       1, 0, 0);           exp_out("e2", 1, 64'h400, 0, 32'h9100_0100, 64'h100);
    drive(0, 0, 0,       0, 1, 32'h9100_0400); exp_out("e3", 0, 64'h400, 0, 32'h9100_0100, 64'h100);
    drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    exp_out("e4", 1, 64'h404, 1, 32'h9100_0400, 64'h400);

    // Top-of-address-space wrap to 0.
    drive(0, 0, 0, 1, 0, 0);        exp_out("f0", 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h9100_0400, 64'h400);
    drive(0, 0, 0, 0, 1, 32'h90FF_FFFC);
    exp_out("f1", 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h9100_0400, 64'h400);
    drive(0, 0, 0, 1, 0, 0);        exp_out("f2", 1, 64'h0, 1, 32'h90FF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 0, 0, 0, 1, 32'h9200_0000);
    exp_out("f3", 0, 64'h0, 0, 32'h90FF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);

    // Stall into S_HOLD, then assert reset mid-cycle.
    drive(1, 0, 0, 1, 0, 0);        exp_out("f4", 1, 64'h4, 1, 32'h9200_0000, 64'h0);
    drive(1, 0, 0, 0, 1, 32'h9200_0004); exp_out("g0", 0, 64'h4, 1, 32'h9200_0000, 64'h0);
    drive(1, 0, 0, 0, 0, 0);        exp_out("g1", 0, 64'h8, 1, 32'h9200_0000, 64'h0);
    #1 reset = 1'b0;
    #1 exp_out("g_rst", 0, 64'h0, 0, 32'h0, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 1, 0, 0);        exp_out("h0", 1, 64'h0, 0, 32'h0, 64'h0);
    drive(0, 0, 0, 0, 1, 32'h9300_0000); exp_out("h1", 0, 64'h0, 0, 32'h0, 64'h0);
    drive(0, 0, 0, 0, 0, 0);        exp_out("h2", 1, 64'h4, 1, 32'h9300_0000, 64'h0);
    drive(0, 0, 0, 0, 0, 0);        exp_out("h3", 1, 64'h4, 0, 32'h9300_0000, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the 64-bit LEGv8 pipeline. It owns the fetch PC register, issues one instruction-memory read at a time over a request/grant/response handshake, and loads fetched instructions into the IF/ID register. It also applies decode-stage stalls and branch redirects (`PCSrc_F` / `PCBranch_F`), including squashing an in-flight wrong-path fetch. It replaces the free-running PC loop of the current fetch stage when instruction memory has variable latency.

## Interface
- `N`, 64, PC/address width
- `RESET_PC`, `64'd0`, first fetch address after reset
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `PCSrc_F`  in  1  branch redirect, one-cycle pulse
- `PCBranch_F`  in  N  redirect target, valid when `PCSrc_F`=1
- `stall_D`  in  1  decode cannot accept; IF/ID must hold
- `imem_req`  out  1  read request valid
- `imem_addr_F`  out  N  read address, stable while `imem_req`=1
- `imem_gnt`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  read data valid; at most one per accepted request
- `imem_rdata`  in  32  instruction word
- `instr_valid_D`  out  1  IF/ID holds a valid instruction
- `instr_D`  out  32  IF/ID instruction
- `pc_D`  out  N  address of `instr_D`

## Operation
- Reset values: PC = `RESET_PC`, state = S_REQ, squash = 0, skid empty, `instr_valid_D`=0, `instr_D`=0, `pc_D`=0.
- `imem_req` = (state==S_REQ) && `reset`, so it is 0 during reset.
- `imem_addr_F` = PC at all times.
- At most one request is outstanding.
- S_REQ: hold the request until `imem_gnt`=1, then go to S_WAIT and latch the request address in `req_pc`.
- S_WAIT: on `imem_rvalid`:
  - If squash=1: drop the data, clear squash, go to S_REQ.
  - Else if slot free (`instr_valid_D`=0 or `stall_D`=0): load IF/ID with {`imem_rdata`, `req_pc`}, set PC = `req_pc`+4, go to S_REQ.
  - Else: write the skid buffer, set PC = `req_pc`+4, go to S_HOLD.
- S_HOLD: when the slot frees, move the skid contents into IF/ID, empty the skid, go to S_REQ. No request is issued while in S_HOLD.
- IF/ID handshake: if `stall_D`=0 and nothing new is loaded, `instr_valid_D` clears. If `stall_D`=1, all IF/ID outputs hold.
- Redirect (`PCSrc_F`=1) has priority over every other event in the same cycle:
  - PC = `PCBranch_F`.
  - `instr_valid_D` = 0 and the skid is emptied, regardless of `stall_D`.
  - S_REQ with `imem_gnt`=1: squash = 1, go to S_WAIT (the granted request was wrong-path).
  - S_REQ without grant: stay in S_REQ; the next request uses the new PC.
  - S_WAIT with `imem_rvalid`=1: drop the data, go to S_REQ.
  - S_WAIT without `imem_rvalid`: squash = 1, stay in S_WAIT.
  - S_HOLD: go to S_REQ.
- PC arithmetic: `req_pc`+4 is modulo 2^N. Address `2^N-4` wraps to 0 with no flag.
- `PCBranch_F` is used as-is; alignment is the producer's responsibility.
- Reset asserted mid-operation returns all state to reset values immediately. A later `imem_rvalid` for a pre-reset request is not supported; the memory is reset with the core.

## Timing
- Grant in cycle t and `imem_rvalid` in cycle t+k (k≥1): `instr_valid_D`=1 from cycle t+k+1 when the slot is free.
- The next request is asserted in cycle t+k+1.
- Peak throughput is one instruction per 2 cycles at k=1.
- Redirect in cycle t: `instr_valid_D`=0 from t+1. `imem_addr_F`=`PCBranch_F` from t+1, or after the squashed response returns.
- No combinational path from `stall_D` or `PCSrc_F` to `imem_req`/`imem_addr_F`.
- Outputs change only on the clock edge or on reset assertion.

## Structure
- Package `fetch_pkg` holds:
  - state enum {S_REQ, S_WAIT, S_HOLD}
  - `INSTR_W` = 32
  - `PC_INC` = 4
- One sub-module, `fetch_skid`: a one-entry {instr, pc} buffer with `load`, `unload` and `flush` inputs and a `full` output.
- The PC+4 increment reuses the existing `adder` module.

## Test plan
- Reset release, memory with k=1, `stall_D`=0 → requests at 0, 4, 8. `instr_valid_D` pulses with `pc_D`=0, 4, 8 and `instr_D` equal to the memory words.
- `stall_D`=1 while IF/ID holds pc 4 and the response for 8 arrives → skid fills, `imem_req`=0. Releasing the stall shows pc 4, then pc 8 on the next cycle, then a request at 12.
- `PCSrc_F`=1 with `PCBranch_F`=0x100 while in S_WAIT at pc 8 with k=3 → the response for 8 is dropped, `instr_valid_D` stays 0, the next request is at 0x100, and `pc_D`=0x100 follows.
- `PCSrc_F` in the same cycle as `imem_gnt` for address 0x20, target 0x400 → the 0x20 data never appears on `instr_D`, and the first valid `pc_D` is 0x400.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC → `pc_D` shows 0xFFFF_FFFF_FFFF_FFFC, then 0x0.
- `reset` asserted low while in S_HOLD → `imem_req`=0, `instr_valid_D`=0 at once. After release, the first request is at `RESET_PC`.
